// File: rtl/axi_lite_master_basic.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_master_basic
// Description : Single-outstanding AXI4-Lite initiator bridging a simple
//               command/response port onto AW/W/B and AR/R channels.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_master_basic #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_write,
    output logic [ADDR_WIDTH-1:0] M_AWADDR,
    output logic                  M_AWVALID,
    input  logic                  M_AWREADY,
    output logic [DATA_WIDTH-1:0] M_WDATA,
    output logic                  M_WVALID,
    input  logic                  M_WREADY,
    input  logic [1:0]            M_BRESP,
    input  logic                  M_BVALID,
    output logic                  M_BREADY,
    output logic [ADDR_WIDTH-1:0] M_ARADDR,
    output logic                  M_ARVALID,
    input  logic                  M_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_RDATA,
    input  logic [1:0]            M_RRESP,
    input  logic                  M_RVALID,
    output logic                  M_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_CPL     = 3'd5
    } state_t;

    state_t                  state_q,     state_d;
    logic                    awvalid_q,   awvalid_d;
    logic                    wvalid_q,    wvalid_d;
    logic                    bready_q,    bready_d;
    logic                    arvalid_q,   arvalid_d;
    logic                    rready_q,    rready_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q,    awaddr_d;
    logic [ADDR_WIDTH-1:0]   araddr_q,    araddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_write_q, rsp_write_d;
    logic [1:0]              rsp_resp_q,  rsp_resp_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    aw_done;
    logic                    w_done;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= S_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_resp_q  <= 2'b00;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_rdata_d = rsp_rdata_q;
        // A channel counts as done once its VALID has already dropped or it handshakes now
        aw_done     = !awvalid_q || M_AWREADY;
        w_done      = !wvalid_q  || M_WREADY;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = S_RD_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                if (awvalid_q && M_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_WREADY)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (M_BVALID && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = M_BRESP;
                    rsp_rdata_d = '0;
                    rsp_write_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_CPL;
                end
            end
            S_RD_REQ: begin
                if (arvalid_q && M_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                if (M_RVALID && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_resp_d  = M_RRESP;
                    rsp_rdata_d = M_RDATA;
                    rsp_write_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_CPL;
                end
            end
            S_CPL: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_write = rsp_write_q;
    assign M_AWADDR  = awaddr_q;
    assign M_AWVALID = awvalid_q;
    assign M_WDATA   = wdata_q;
    assign M_WVALID  = wvalid_q;
    assign M_BREADY  = bready_q;
    assign M_ARADDR  = araddr_q;
    assign M_ARVALID = arvalid_q;
    assign M_RREADY  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master_basic.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_master_basic
// Description : Directed bench with a scoreboard of expected completions and
//               a configurable-latency AXI4-Lite slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master_basic;

    logic        ACLK;
    logic        ARESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [3:0]  M_AWADDR, M_ARADDR;
    logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
    logic [31:0] M_WDATA, M_RDATA;
    logic [1:0]  M_BRESP, M_RRESP;
    logic        M_BVALID, M_BREADY, M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

    axi_lite_master_basic #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_write(rsp_write),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rsp_cnt  = 0;
    int prot_err = 0;
    logic [34:0] exp_q[$];

    int aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] mem [16];
    logic [3:0]  last_awaddr, last_araddr;
    logic [31:0] last_wdata;
    int last_aw_len, last_w_len, last_ar_len;
    int acc_cyc;

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave model: all decisions taken on the falling edge so values seen here equal those at the next rising edge
    initial begin : slave
        logic pv_awvalid, pv_wvalid, pv_arvalid, pv_bready, pv_rready;
        logic [3:0]  pv_awaddr, pv_araddr;
        logic [31:0] pv_wdata;
        logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
        logic aw_done, w_done, ar_done, b_arm;
        int aw_cnt, w_cnt, ar_cnt, aw_vc, w_vc, ar_vc;
        M_AWREADY = 0; M_WREADY = 0; M_ARREADY = 0; M_BVALID = 0; M_RVALID = 0;
        M_BRESP = 0; M_RRESP = 0; M_RDATA = 0;
        pv_awvalid = 0; pv_wvalid = 0; pv_arvalid = 0; pv_bready = 0; pv_rready = 0;
        pv_awaddr = 0; pv_araddr = 0; pv_wdata = 0;
        aw_done = 0; w_done = 0; ar_done = 0; b_arm = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_vc = 0; w_vc = 0; ar_vc = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                M_AWREADY = 0; M_WREADY = 0; M_ARREADY = 0; M_BVALID = 0; M_RVALID = 0;
                pv_awvalid = 0; pv_wvalid = 0; pv_arvalid = 0; pv_bready = 0; pv_rready = 0;
                aw_done = 0; w_done = 0; ar_done = 0; b_arm = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_vc = 0; w_vc = 0; ar_vc = 0;
            end else begin
                aw_hs = pv_awvalid && M_AWREADY;
                w_hs  = pv_wvalid  && M_WREADY;
                ar_hs = pv_arvalid && M_ARREADY;
                b_hs  = M_BVALID && pv_bready;
                r_hs  = M_RVALID && pv_rready;
                if (aw_hs) begin last_awaddr = pv_awaddr; last_aw_len = aw_vc; aw_vc = 0; aw_done = 1; end
                if (w_hs)  begin last_wdata  = pv_wdata;  last_w_len  = w_vc;  w_vc  = 0; w_done  = 1; end
                if (b_hs)  begin M_BVALID = 0; aw_done = 0; w_done = 0; end
                if (b_arm) begin M_BVALID = 1; M_BRESP = bresp_cfg; b_arm = 0; end
                if ((aw_hs || w_hs) && aw_done && w_done) begin
                    mem[last_awaddr] = last_wdata;
                    b_arm = 1;
                end
                if (r_hs) begin M_RVALID = 0; ar_done = 0; end
                if (ar_hs) begin
                    last_araddr = pv_araddr; last_ar_len = ar_vc; ar_vc = 0; ar_done = 1;
                    M_RVALID = 1; M_RDATA = mem[pv_araddr]; M_RRESP = rresp_cfg;
                end
                if (pv_awvalid && !aw_hs && (!M_AWVALID || M_AWADDR != pv_awaddr)) prot_err++;
                if (pv_wvalid  && !w_hs  && (!M_WVALID  || M_WDATA  != pv_wdata))  prot_err++;
                if (pv_arvalid && !ar_hs && (!M_ARVALID || M_ARADDR != pv_araddr)) prot_err++;
                if (M_BREADY && !(aw_done && w_done)) prot_err++;
                if (M_RREADY && !ar_done) prot_err++;
                if (M_AWVALID) begin
                    aw_vc++;
                    if (aw_cnt >= aw_delay) M_AWREADY = 1; else begin M_AWREADY = 0; aw_cnt++; end
                end else begin M_AWREADY = 0; aw_cnt = 0; end
                if (M_WVALID) begin
                    w_vc++;
                    if (w_cnt >= w_delay) M_WREADY = 1; else begin M_WREADY = 0; w_cnt++; end
                end else begin M_WREADY = 0; w_cnt = 0; end
                if (M_ARVALID) begin
                    ar_vc++;
                    if (ar_cnt >= ar_delay) M_ARREADY = 1; else begin M_ARREADY = 0; ar_cnt++; end
                end else begin M_ARREADY = 0; ar_cnt = 0; end
                pv_awvalid = M_AWVALID; pv_awaddr = M_AWADDR;
                pv_wvalid  = M_WVALID;  pv_wdata  = M_WDATA;
                pv_arvalid = M_ARVALID; pv_araddr = M_ARADDR;
                pv_bready  = M_BREADY;  pv_rready = M_RREADY;
            end
        end
    end

    // Completion monitor: pops the scoreboard on every accepted completion
    initial begin : monitor
        logic        hold_v;
        logic [34:0] held, e;
        hold_v = 0;
        held   = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                hold_v = 0;
            end else begin
                if (rsp_valid && hold_v) check("rsp_stable", {rsp_write, rsp_resp, rsp_rdata}, held);
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rsp_unexpected: got %0h expected none", {rsp_write, rsp_resp, rsp_rdata});
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp", {rsp_write, rsp_resp, rsp_rdata}, e);
                        rsp_cnt++;
                    end
                end
                hold_v = rsp_valid && !rsp_ready;
                held   = {rsp_write, rsp_resp, rsp_rdata};
            end
        end
    end

    task automatic send(input logic wr, input logic [3:0] a, input logic [31:0] d, input bit keep);
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !cmd_ready; i++) begin @(posedge ACLK); #2; end
        if (!cmd_ready) begin
            n_checks++; n_errors++;
            $display("FAIL cmd_accept: got timeout expected cmd_ready");
        end
        @(posedge ACLK); #2;
        if (!keep) cmd_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!rsp_valid && n < 100) begin @(posedge ACLK); #2; n++; end
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 200 && rsp_cnt < target; i++) begin @(posedge ACLK); #2; end
        check("rsp_count", rsp_cnt, target);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, c0;
        bit ok;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        ARESETn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 1;
        repeat (3) @(posedge ACLK);
        #2;
        check("rst_ready", cmd_ready, 1);
        check("rst_valids", {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid, rsp_write}, 0);
        check("rst_addr_data", {M_AWADDR, M_ARADDR, M_WDATA}, 0);
        check("rst_rsp", {rsp_rdata, rsp_resp}, 0);
        ARESETn = 1;
        @(posedge ACLK); #2;

        // basic write, always-ready slave
        exp_q.push_back({1'b1, 2'b00, 32'h0});
        send(1'b1, 4'h0, 32'hA5A5A5A5, 0);
        wait_valid(n);
        check("wr_latency", n, 3);
        wait_done(1);
        check("wr1_awaddr", last_awaddr, 4'h0);
        check("wr1_wdata", last_wdata, 32'hA5A5A5A5);
        check("wr1_lens", {last_aw_len[7:0], last_w_len[7:0]}, {8'd1, 8'd1});

        // AWREADY late, then WREADY late
        aw_delay = 3;
        exp_q.push_back({1'b1, 2'b00, 32'h0});
        send(1'b1, 4'h3, 32'h12345678, 0);
        wait_done(2);
        check("wr2_awaddr", last_awaddr, 4'h3);
        check("wr2_lens", {last_aw_len[7:0], last_w_len[7:0]}, {8'd4, 8'd1});
        aw_delay = 0; w_delay = 3;
        exp_q.push_back({1'b1, 2'b00, 32'h0});
        send(1'b1, 4'h7, 32'hDEADBEEF, 0);
        wait_done(3);
        check("wr3_wdata", last_wdata, 32'hDEADBEEF);
        check("wr3_lens", {last_aw_len[7:0], last_w_len[7:0]}, {8'd1, 8'd4});
        w_delay = 0;

        // read back with ARREADY late
        ar_delay = 2;
        exp_q.push_back({1'b0, 2'b00, 32'hA5A5A5A5});
        send(1'b0, 4'h0, 32'h0, 0);
        wait_done(4);
        check("rd1_araddr", last_araddr, 4'h0);
        check("rd1_arlen", last_ar_len, 3);
        ar_delay = 0;

        // SLVERR read held in CPL while rsp_ready is low
        rsp_ready = 0; rresp_cfg = 2'b10;
        exp_q.push_back({1'b0, 2'b10, 32'h12345678});
        send(1'b0, 4'h3, 32'h0, 0);
        wait_valid(n);
        ok = 1;
        for (int k = 0; k < 5; k++) begin
            if (!(rsp_valid && rsp_resp == 2'b10 && rsp_rdata == 32'h12345678 && !cmd_ready)) ok = 0;
            @(posedge ACLK); #2;
        end
        check("cpl_hold", ok, 1);
        rsp_ready = 1;
        @(posedge ACLK); #2;
        check("cpl_to_idle", {cmd_ready, rsp_valid}, 2'b10);
        wait_done(5);
        rresp_cfg = 2'b00;

        // back-to-back write (DECERR) then read, cmd_valid held high
        bresp_cfg = 2'b11;
        exp_q.push_back({1'b1, 2'b11, 32'h0});
        exp_q.push_back({1'b0, 2'b00, 32'h0F0F0F0F});
        send(1'b1, 4'h5, 32'h0F0F0F0F, 1);
        c0 = acc_cyc;
        send(1'b0, 4'h5, 32'h0, 0);
        check("b2b_gap", acc_cyc - c0, 5);
        wait_done(7);
        bresp_cfg = 2'b00;

        // asynchronous reset while stuck in WR_REQ
        aw_delay = 1000; w_delay = 1000;
        send(1'b1, 4'h9, 32'hCAFEF00D, 0);
        check("inflight_awvalid", M_AWVALID, 1);
        #1 ARESETn = 0;
        #1;
        check("rst_async_valids", {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid}, 0);
        check("rst_async_addr", {M_AWADDR, M_WDATA}, 0);
        @(posedge ACLK); @(posedge ACLK); #2;
        ARESETn = 1; aw_delay = 0; w_delay = 0;
        @(posedge ACLK); #2;
        check("post_rst_idle", {cmd_ready, rsp_valid}, 2'b10);

        // read latency with always-ready slave
        exp_q.push_back({1'b0, 2'b00, 32'hDEADBEEF});
        send(1'b0, 4'h7, 32'h0, 0);
        wait_valid(n);
        check("rd_latency", n, 2);
        wait_done(8);
        check("rd2_arlen", last_ar_len, 1);

        repeat (3) @(posedge ACLK);
        #2;
        check("protocol", prot_err, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
